// File: rtl/soc_decerr_slave_pkg.sv
// Shared SoC definitions for the crossbar default (decode-error) slave:
// slave-side ID width, DECERR code, FSM state types and a saturating adder.
package soc_decerr_slave_pkg;

    localparam int unsigned SlvIdWidth = 6;
    localparam logic [1:0]  RespDecErr = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Counter add that pins at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/soc_decerr_rd_fsm.sv
// Read side of the decode-error slave: accepts one AR at a time and returns
// ar_len+1 DECERR beats with zero data.
module soc_decerr_rd_fsm
    import soc_decerr_slave_pkg::*;
#(
    parameter int unsigned IdWidth   = SlvIdWidth,
    parameter int unsigned DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic                 r_last_o,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o
);

    rd_state_e          state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [IdWidth-1:0] id_q, id_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= R_IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
        end
    end

    // Outputs depend only on registered state, so they hold while stalled.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        ar_ready_o = 1'b0;
        r_valid_o  = 1'b0;
        r_last_o   = 1'b0;
        case (state_q)
            R_IDLE: begin
                ar_ready_o = 1'b1;
                if (ar_valid_i) begin
                    id_d    = ar_id_i;
                    cnt_d   = ar_len_i;
                    state_d = R_DATA;
                end
            end
            R_DATA: begin
                r_valid_o = 1'b1;
                r_last_o  = (cnt_q == 8'd0);
                if (r_ready_i) begin
                    if (cnt_q == 8'd0) state_d = R_IDLE;
                    else               cnt_d   = cnt_q - 8'd1;
                end
            end
        endcase
    end

    assign r_id_o   = id_q;
    assign r_data_o = '0;
    assign r_resp_o = RespDecErr;

endmodule

// File: rtl/soc_decerr_slave.sv
// Crossbar default slave: answers every unmapped AXI transaction with DECERR
// and logs how many were seen plus the address of the latest one.
module soc_decerr_slave
    import soc_decerr_slave_pkg::*;
#(
    parameter int unsigned IdWidth   = SlvIdWidth,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic                 r_last_o,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic [31:0]          err_cnt_o,
    output logic [AddrWidth-1:0] err_addr_o
);

    wr_state_e            w_state_q, w_state_d;
    logic [IdWidth-1:0]   w_id_q, w_id_d;
    logic [31:0]          err_cnt_q;
    logic [AddrWidth-1:0] err_addr_q;
    logic                 aw_hs, ar_hs;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
        end
    end

    // W data is dropped; only the last-beat marker matters.
    always_comb begin
        w_state_d  = w_state_q;
        w_id_d     = w_id_q;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                aw_ready_o = 1'b1;
                if (aw_valid_i) begin
                    w_id_d    = aw_id_i;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                w_ready_o = 1'b1;
                if (w_valid_i && w_last_i) w_state_d = W_RESP;
            end
            W_RESP: begin
                b_valid_o = 1'b1;
                if (b_ready_i) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign b_id_o   = w_id_q;
    assign b_resp_o = RespDecErr;

    soc_decerr_rd_fsm #(
        .IdWidth  (IdWidth),
        .DataWidth(DataWidth)
    ) u_rd_fsm (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .ar_valid_i(ar_valid_i),
        .ar_ready_o(ar_ready_o),
        .ar_id_i   (ar_id_i),
        .ar_len_i  (ar_len_i),
        .r_valid_o (r_valid_o),
        .r_ready_i (r_ready_i),
        .r_last_o  (r_last_o),
        .r_id_o    (r_id_o),
        .r_data_o  (r_data_o),
        .r_resp_o  (r_resp_o)
    );

    assign aw_hs = aw_valid_i & aw_ready_o;
    assign ar_hs = ar_valid_i & ar_ready_o;

    // AW wins the address log when both channels handshake together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            if (aw_hs || ar_hs)
                err_cnt_q <= sat_add32(err_cnt_q, {1'b0, aw_hs} + {1'b0, ar_hs});
            if (aw_hs)
                err_addr_q <= aw_addr_i;
            else if (ar_hs)
                err_addr_q <= ar_addr_i;
        end
    end

    assign err_cnt_o  = err_cnt_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_soc_decerr_slave.sv
// Randomized self-checking bench for soc_decerr_slave against a transaction-level model.
module tb_soc_decerr_slave;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        aw_valid = 1'b0, aw_ready;
    logic [5:0]  aw_id = '0;
    logic [63:0] aw_addr = '0;
    logic        w_valid = 1'b0, w_ready, w_last = 1'b0;
    logic        b_valid, b_ready = 1'b0;
    logic [5:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_valid = 1'b0, ar_ready;
    logic [5:0]  ar_id = '0;
    logic [63:0] ar_addr = '0;
    logic [7:0]  ar_len = '0;
    logic        r_valid, r_ready = 1'b0, r_last;
    logic [5:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic [31:0] err_cnt;
    logic [63:0] err_addr;

    int          checks = 0;
    int          failures = 0;
    longint      model_cnt = 0;
    logic [63:0] model_addr = '0;

    always #5 clk = ~clk;

    soc_decerr_slave dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
        .ar_len_i(ar_len),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_last_o(r_last), .r_id_o(r_id),
        .r_data_o(r_data), .r_resp_o(r_resp),
        .err_cnt_o(err_cnt), .err_addr_o(err_addr)
    );

    function automatic void model_log(input int n, input logic [63:0] addr);
        model_cnt = model_cnt + n;
        if (model_cnt > 64'hFFFF_FFFF) model_cnt = 64'hFFFF_FFFF;
        model_addr = addr;
    endfunction

    task automatic do_write(input logic [5:0] id, input logic [63:0] addr, input int nbeats,
                            input bit upd);
        int beats = 0;
        int cyc = 0;
        int stall;
        @(negedge clk);
        aw_valid = 1'b1; aw_id = id; aw_addr = addr;
        #1 checks++;
        if (aw_ready !== 1'b1) begin failures++; $display("FAIL aw_ready got=%b exp=1", aw_ready); end
        @(posedge clk);
        if (upd) model_log(1, addr);
        @(negedge clk);
        aw_valid = 1'b0; aw_id = 6'($urandom); aw_addr = {$urandom, $urandom};
        while (beats < nbeats && cyc < 1000) begin
            w_valid = ($urandom_range(0, 3) != 0);
            w_last  = (beats == nbeats - 1);
            #1 checks++;
            if (w_ready !== 1'b1 || b_valid !== 1'b0 || aw_ready !== 1'b0) begin
                failures++;
                $display("FAIL w_phase got w_ready=%b b_valid=%b aw_ready=%b exp 1/0/0", w_ready, b_valid, aw_ready);
            end
            @(posedge clk);
            if (w_valid) beats++;
            @(negedge clk);
            cyc++;
        end
        w_valid = 1'b0; w_last = 1'b0;
        if (cyc >= 1000) begin failures++; $display("FAIL w_timeout got beats=%0d exp=%0d", beats, nbeats); end
        stall = $urandom_range(0, 3);
        for (int k = 0; k <= stall; k++) begin
            #1 checks++;
            if (b_valid !== 1'b1 || b_id !== id || b_resp !== 2'b11 || w_ready !== 1'b0) begin
                failures++;
                $display("FAIL b_resp got valid=%b id=%0d resp=%b w_ready=%b exp 1/%0d/11/0", b_valid, b_id, b_resp, w_ready, id);
            end
            if (k == stall) b_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        b_ready = 1'b0;
        #1 checks++;
        if (b_valid !== 1'b0 || aw_ready !== 1'b1) begin
            failures++;
            $display("FAIL b_done got b_valid=%b aw_ready=%b exp 0/1", b_valid, aw_ready);
        end
    endtask

    // mode 0: r_ready alternates 1/0; mode 1: random back-pressure
    task automatic do_read(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input int mode, input bit upd);
        int beats = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [5:0]  p_id = '0;
        logic        p_last = 1'b0;
        logic [63:0] p_data = '0;
        @(negedge clk);
        ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len;
        #1 checks++;
        if (ar_ready !== 1'b1) begin failures++; $display("FAIL ar_ready got=%b exp=1", ar_ready); end
        @(posedge clk);
        if (upd) model_log(1, addr);
        @(negedge clk);
        ar_valid = 1'b0; ar_id = 6'($urandom); ar_len = 8'($urandom); ar_addr = {$urandom, $urandom};
        while (beats <= int'(len) && cyc < 2000) begin
            r_ready = (mode == 0) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            #1 checks++;
            if (r_valid !== 1'b1 || r_data !== 64'd0 || r_id !== id || r_resp !== 2'b11 ||
                r_last !== (beats == int'(len)) || ar_ready !== 1'b0) begin
                failures++;
                $display("FAIL r_beat%0d got valid=%b data=%0h id=%0d resp=%b last=%b exp 1/0/%0d/11/%b",
                         beats, r_valid, r_data, r_id, r_resp, r_last, id, beats == int'(len));
            end
            if (stalled) begin
                checks++;
                if (r_id !== p_id || r_last !== p_last || r_data !== p_data) begin
                    failures++;
                    $display("FAIL r_stable got id=%0d last=%b exp id=%0d last=%b", r_id, r_last, p_id, p_last);
                end
            end
            p_id = r_id; p_last = r_last; p_data = r_data; stalled = !r_ready;
            @(posedge clk);
            if (r_ready) beats++;
            @(negedge clk);
            cyc++;
        end
        r_ready = 1'b0;
        if (cyc >= 2000) begin failures++; $display("FAIL r_timeout got beats=%0d exp=%0d", beats, len + 1); end
        #1 checks++;
        if (r_valid !== 1'b0 || r_last !== 1'b0 || ar_ready !== 1'b1) begin
            failures++;
            $display("FAIL r_done got r_valid=%b r_last=%b ar_ready=%b exp 0/0/1", r_valid, r_last, ar_ready);
        end
    endtask

    task automatic check_log(input string name);
        checks++;
        if (err_cnt !== model_cnt[31:0] || err_addr !== model_addr) begin
            failures++;
            $display("FAIL %s got cnt=%0h addr=%0h exp cnt=%0h addr=%0h", name, err_cnt, err_addr, model_cnt[31:0], model_addr);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        model_cnt = 0; model_addr = '0;
        #1 checks++;
        if (aw_ready !== 1'b1 || ar_ready !== 1'b1 || b_valid !== 1'b0 || r_valid !== 1'b0 ||
            w_ready !== 1'b0 || r_last !== 1'b0 || b_resp !== 2'b11 || r_resp !== 2'b11) begin
            failures++;
            $display("FAIL reset_ctrl got aw_rdy=%b ar_rdy=%b b_v=%b r_v=%b w_rdy=%b r_last=%b",
                     aw_ready, ar_ready, b_valid, r_valid, w_ready, r_last);
        end
        check_log("reset_log");
    endtask

    task automatic test_write();
        do_write(6'd5, 64'h5000_0000, 3, 1'b1);
        check_log("write_log");
    endtask

    task automatic test_read();
        do_read(6'd9, 64'h4000_1000, 8'd3, 0, 1'b1);
        check_log("read_log");
        do_read(6'd33, 64'h4000_2000, 8'd0, 1, 1'b1);
        check_log("read_len0_log");
    endtask

    task automatic test_simultaneous();
        model_log(2, 64'h7000_0000);
        fork
            do_write(6'd12, 64'h7000_0000, 2, 1'b0);
            do_read(6'd40, 64'h6000_0000, 8'd2, 1, 1'b0);
        join
        check_log("simul_log");
    endtask

    task automatic test_saturate();
        @(negedge clk);
        force dut.err_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.err_cnt_q;
        model_cnt = 64'hFFFF_FFFE;
        do_read(6'd1, 64'h8000_0000, 8'd1, 1, 1'b1);
        check_log("sat_first");
        do_read(6'd2, 64'h8000_0100, 8'd0, 1, 1'b1);
        check_log("sat_second");
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        ar_valid = 1'b1; ar_id = 6'd17; ar_addr = 64'h9000_0000; ar_len = 8'd7;
        @(posedge clk);
        @(negedge clk);
        ar_valid = 1'b0; r_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_ni = 1'b0;
        model_cnt = 0; model_addr = '0;
        #1 checks++;
        if (r_valid !== 1'b0 || r_last !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_rvalid got r_valid=%b r_last=%b exp 0/0", r_valid, r_last);
        end
        check_log("rst_mid_log");
        @(negedge clk);
        r_ready = 1'b0; rst_ni = 1'b1;
        #1 checks++;
        if (ar_ready !== 1'b1 || aw_ready !== 1'b1 || r_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_release got ar_ready=%b aw_ready=%b r_valid=%b exp 1/1/0", ar_ready, aw_ready, r_valid);
        end
        check_log("rst_mid_release_log");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(6'($urandom), {$urandom, $urandom}, $urandom_range(1, 5), 1'b1);
            else
                do_read(6'($urandom), {$urandom, $urandom}, 8'($urandom_range(0, 9)), 1, 1'b1);
            check_log("random_log");
        end
    endtask

    task automatic test_back_to_back();
        do_read(6'd3, 64'hA000_0000, 8'd2, 1, 1'b1);
        do_read(6'd4, 64'hA000_0040, 8'd1, 0, 1'b1);
        do_write(6'd6, 64'hB000_0000, 1, 1'b1);
        check_log("b2b_log");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_simultaneous();
        test_back_to_back();
        test_random();
        test_saturate();
        test_reset_mid_burst();
        test_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
